// File: rtl/present_enc_core_if.sv
// Request/response bundle for the PRESENT-80 encryption core.
// The master drives plaintext/key requests and accepts ciphertext; the slave is the core.
interface present_enc_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ciphertext;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext
  );
endinterface

// File: rtl/present_enc_core.sv
// Iterative PRESENT-80 encryptor, one round per clock; PRESENT_ZEROIZE_EN clears secrets after output.
// Latency: out_valid rises ROUNDS edges after the accepting edge; issue interval ROUNDS + 2.
// Backpressure: result held in DONE until out_ready; no new request accepted until then.
module present_enc_core #(
  parameter int ROUNDS = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  present_enc_core_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  fsm_t        fsm;
  logic [63:0] state_reg;
  logic [79:0] key_reg;
  logic [4:0]  round_ctr;
  logic        out_valid_r;

  logic [63:0] mixed;
  logic [63:0] subbed;
  logic [63:0] permuted;
  logic [79:0] key_rot;
  logic [79:0] key_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // (16*i) mod 63 rewritten as i/4 + 16*(i%4), which also maps bit 63 onto itself.
  function automatic logic [63:0] player(input logic [63:0] s);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      p[(i / 4) + 16 * (i % 4)] = s[i];
    end
    return p;
  endfunction

  always_comb begin
    mixed = state_reg ^ key_reg[79:16];
    subbed = '0;
    for (int n = 0; n < 16; n++) begin
      subbed[4*n +: 4] = sbox(mixed[4*n +: 4]);
    end
    permuted = player(subbed);

    key_rot  = {key_reg[18:0], key_reg[79:19]};
    key_next = key_rot;
    key_next[79:76] = sbox(key_rot[79:76]);
    key_next[19:15] = key_rot[19:15] ^ round_ctr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      state_reg   <= '0;
      key_reg     <= '0;
      round_ctr   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg <= bus.plaintext;
            key_reg   <= bus.key;
            round_ctr <= 5'd1;
            fsm       <= RUN;
          end
        end
        RUN: begin
          key_reg <= key_next;
          if (round_ctr == LAST_ROUND) begin
            state_reg   <= permuted ^ key_next[79:16];
            out_valid_r <= 1'b1;
            fsm         <= DONE;
          end else begin
            state_reg <= permuted;
            round_ctr <= round_ctr + 5'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            fsm         <= IDLE;
`ifdef PRESENT_ZEROIZE_EN
            state_reg   <= '0;
            key_reg     <= '0;
`endif
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (fsm == IDLE);
  assign bus.out_valid = out_valid_r;
`ifdef PRESENT_ZEROIZE_EN
  assign bus.ciphertext = out_valid_r ? state_reg : 64'h0;
`else
  assign bus.ciphertext = state_reg;
`endif

endmodule

// File: tb/tb_present_enc_core.sv
// Directed-vector bench for present_enc_core using the published PRESENT-80 test vectors.
module tb_present_enc_core;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  localparam logic [63:0] CT_00 = 64'h5579C1387B228445;
  localparam logic [63:0] CT_0F = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT_F0 = 64'hA112FFC72F68417B;
  localparam logic [63:0] CT_FF = 64'h3333DCD3213210D2;
  localparam logic [63:0] PT_F  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [79:0] K_F   = 80'hFFFFFFFFFFFFFFFFFFFF;

  present_enc_core_if bus ();

  present_enc_core #(.ROUNDS(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request and hold it through one rising edge; caller ensures the core is idle.
  task automatic send(input logic [63:0] pt, input logic [79:0] k);
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid is seen (bounded); returns at a negedge.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 100);
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    #3;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    vectors++;
    if (bus.ciphertext !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_ciphertext: got %h expected 0", bus.ciphertext);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    send(64'h0, 80'h0);
    wait_out(lat);
    vectors++;
    if (lat !== 31) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected 31", lat);
    end
    vectors++;
    if (bus.ciphertext !== CT_00) begin
      miscompares++;
      $display("FAIL basic_ct: got %h expected %h", bus.ciphertext, CT_00);
    end
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_in_ready_done: got %b expected 0", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_handshake: got out_valid=%b in_ready=%b expected 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_zeroize;
    @(negedge clk);
`ifdef PRESENT_ZEROIZE_EN
    vectors++;
    if (bus.ciphertext !== 64'h0) begin
      miscompares++;
      $display("FAIL zeroize_ct: got %h expected 0", bus.ciphertext);
    end
    vectors++;
    if (dut.key_reg !== 80'h0 || dut.state_reg !== 64'h0) begin
      miscompares++;
      $display("FAIL zeroize_regs: got key=%h state=%h expected 0", dut.key_reg, dut.state_reg);
    end
`else
    vectors++;
    if (bus.ciphertext !== CT_00) begin
      miscompares++;
      $display("FAIL retain_ct: got %h expected %h", bus.ciphertext, CT_00);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    bus.out_ready = 1'b1;
    send(64'h0, K_F);
    wait_out(lat);
    vectors++;
    if (lat !== 31 || bus.ciphertext !== CT_0F) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d ct=%h expected 31/%h", lat, bus.ciphertext, CT_0F);
    end
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_in_ready_done: got %b expected 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_turnaround: got in_ready=%b out_valid=%b expected 1/0",
               bus.in_ready, bus.out_valid);
    end
    send(PT_F, 80'h0);
    wait_out(lat);
    vectors++;
    if (lat !== 31 || bus.ciphertext !== CT_F0) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d ct=%h expected 31/%h", lat, bus.ciphertext, CT_F0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat;
    send(PT_F, K_F);
    wait_out(lat);
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.ciphertext !== CT_FF || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b ct=%h in_ready=%b expected 1/%h/0",
                 c, bus.out_valid, bus.ciphertext, bus.in_ready, CT_FF);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept: got out_valid=%b in_ready=%b expected 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_ignore_in_valid;
    int lat;
    int bad_ready;
    bad_ready = 0;
    send(64'h0, 80'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) bad_ready++;
      bus.in_valid  = c[0];
      bus.plaintext = {16{c[3:0]}};
      bus.key       = {20{~c[3:0]}};
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if (bad_ready !== 0) begin
      miscompares++;
      $display("FAIL ignore_in_ready: got %0d cycles with in_ready=1 expected 0", bad_ready);
    end
    wait_out(lat);
    vectors++;
    if (bus.ciphertext !== CT_00) begin
      miscompares++;
      $display("FAIL ignore_ct: got %h expected %h", bus.ciphertext, CT_00);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_midrun_reset;
    int lat;
    int seen;
    send(PT_F, 80'h0);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ciphertext !== 64'h0) begin
      miscompares++;
      $display("FAIL midrst_async: got out_valid=%b in_ready=%b ct=%h expected 0/1/0",
               bus.out_valid, bus.in_ready, bus.ciphertext);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen !== 0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_no_pulse: got %0d out_valid cycles in_ready=%b expected 0/1",
               seen, bus.in_ready);
    end
    send(64'h0, K_F);
    wait_out(lat);
    vectors++;
    if (lat !== 31 || bus.ciphertext !== CT_0F) begin
      miscompares++;
      $display("FAIL midrst_recover: got lat=%0d ct=%h expected 31/%h", lat, bus.ciphertext, CT_0F);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_zeroize();
    test_back_to_back();
    test_backpressure();
    test_ignore_in_valid();
    test_midrun_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
